// File: rtl/ddr_wr_burst.sv
// AXI write-burst engine: walks a strided 2-D region of DDR, splitting each row
// into AXI bursts that never exceed MAX_LEN beats or cross a 4 KB page.
//
//  state  | meaning
//  IDLE   | waiting for start; done high
//  ADDR   | presenting the next chunk on AW (held off while MAX_OUT bursts are open)
//  DATA   | streaming the chunk's beats from din straight onto W
//  WAIT_B | all data sent; waiting for every outstanding B response
module ddr_wr_burst #(
    parameter int DDR_ADDR_W = 32,
    parameter int BURST_W    = 16,
    parameter int DATA_W     = 256,
    parameter int MAX_LEN    = 16,
    parameter int MAX_OUT    = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [DDR_ADDR_W-1:0] st_addr,
    input  logic [BURST_W-1:0]    burst,
    input  logic [DDR_ADDR_W-1:0] step,
    input  logic [BURST_W-1:0]    burst_num,
    output logic                  done,
    input  logic [DATA_W-1:0]     din,
    input  logic                  din_valid,
    output logic                  din_ready,
    output logic [DDR_ADDR_W-1:0] awaddr,
    output logic [7:0]            awlen,
    output logic                  awvalid,
    input  logic                  awready,
    output logic [DATA_W-1:0]     wdata,
    output logic [DATA_W/8-1:0]   wstrb,
    output logic                  wlast,
    output logic                  wvalid,
    input  logic                  wready,
    input  logic                  bvalid,
    output logic                  bready
);

    localparam int BEAT_W = BURST_W - 5;
    localparam int CW     = (BEAT_W > 13) ? BEAT_W : 13;
    localparam int CLW    = 9;
    localparam int OUT_W  = $clog2(MAX_OUT + 1);

    typedef enum logic [1:0] {IDLE, ADDR, DATA, WAIT_B} state_t;

    state_t                 state_q;
    logic                   done_q;
    logic [DDR_ADDR_W-1:0]  addr_q;
    logic [DDR_ADDR_W-1:0]  row_base_q;
    logic [DDR_ADDR_W-1:0]  step_q;
    logic [BEAT_W-1:0]      row_beats_q;
    logic [BEAT_W-1:0]      row_left_q;
    logic [BURST_W-1:0]     rows_left_q;
    logic [CLW-1:0]         chunk_left_q;
    logic [OUT_W-1:0]       out_q;
    logic [OUT_W-1:0]       out_d;

    logic [BEAT_W-1:0]      start_beats;
    logic [DDR_ADDR_W-1:0]  next_base;
    logic [CW-1:0]          bnd_beats;
    logic [CW-1:0]          chunk_beats;
    logic                   aw_hs;
    logic                   w_hs;
    logic                   b_hs;

    assign start_beats = BEAT_W'(burst >> 5);
    assign next_base   = row_base_q + step_q;

    // Beats left before the 4 KB page ends; address is always 32 B aligned here.
    assign bnd_beats = (CW'(4096) - CW'(addr_q[11:0])) >> 5;

    always_comb begin
        chunk_beats = CW'(row_left_q);
        if (chunk_beats > CW'(MAX_LEN)) chunk_beats = CW'(MAX_LEN);
        if (chunk_beats > bnd_beats)    chunk_beats = bnd_beats;
    end

    assign awvalid   = (state_q == ADDR) && (out_q < OUT_W'(MAX_OUT));
    assign awaddr    = addr_q;
    assign awlen     = 8'(chunk_beats - CW'(1));

    assign wvalid    = (state_q == DATA) && din_valid;
    assign din_ready = (state_q == DATA) && wready;
    assign wdata     = din;
    assign wstrb     = '1;
    assign wlast     = (state_q == DATA) && (chunk_left_q == CLW'(1));

    assign bready    = 1'b1;
    assign done      = done_q;

    assign aw_hs = awvalid && awready;
    assign w_hs  = wvalid && wready;
    assign b_hs  = bvalid && (out_q != '0);

    always_comb begin
        out_d = out_q;
        if (aw_hs && !b_hs)      out_d = out_q + OUT_W'(1);
        else if (!aw_hs && b_hs) out_d = out_q - OUT_W'(1);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            done_q       <= 1'b1;
            addr_q       <= '0;
            row_base_q   <= '0;
            step_q       <= '0;
            row_beats_q  <= '0;
            row_left_q   <= '0;
            rows_left_q  <= '0;
            chunk_left_q <= '0;
            out_q        <= '0;
        end else begin
            out_q <= out_d;
            case (state_q)
                IDLE: begin
                    done_q <= 1'b1;
                    if (start) begin
                        done_q      <= 1'b0;
                        addr_q      <= st_addr & ~DDR_ADDR_W'(31);
                        row_base_q  <= st_addr & ~DDR_ADDR_W'(31);
                        step_q      <= step & ~DDR_ADDR_W'(31);
                        row_beats_q <= start_beats;
                        row_left_q  <= start_beats;
                        rows_left_q <= burst_num;
                        if (start_beats != '0) state_q <= ADDR;
                    end
                end
                ADDR: begin
                    if (aw_hs) begin
                        chunk_left_q <= CLW'(chunk_beats);
                        state_q      <= DATA;
                    end
                end
                DATA: begin
                    if (w_hs) begin
                        addr_q       <= addr_q + DDR_ADDR_W'(32);
                        row_left_q   <= row_left_q - BEAT_W'(1);
                        chunk_left_q <= chunk_left_q - CLW'(1);
                        if (chunk_left_q == CLW'(1)) begin
                            state_q <= ADDR;
                            if (row_left_q == BEAT_W'(1)) begin
                                if (rows_left_q == '0) begin
                                    state_q <= WAIT_B;
                                end else begin
                                    rows_left_q <= rows_left_q - BURST_W'(1);
                                    row_base_q  <= next_base;
                                    addr_q      <= next_base;
                                    row_left_q  <= row_beats_q;
                                end
                            end
                        end
                    end
                end
                WAIT_B: begin
                    if (out_q == '0) begin
                        state_q <= IDLE;
                        done_q  <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ddr_wr_burst.sv
// Directed bench for ddr_wr_burst: logs AW/W/B handshakes on the falling edge
// and compares them with hand-computed burst lists.
module tb_ddr_wr_burst;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [31:0]  st_addr;
    logic [15:0]  burst;
    logic [31:0]  step;
    logic [15:0]  burst_num;
    logic         done;
    logic [255:0] din;
    logic         din_valid;
    logic         din_ready;
    logic [31:0]  awaddr;
    logic [7:0]   awlen;
    logic         awvalid;
    logic         awready;
    logic [255:0] wdata;
    logic [31:0]  wstrb;
    logic         wlast;
    logic         wvalid;
    logic         wready;
    logic         bvalid;
    logic         bready;

    ddr_wr_burst dut (
        .clk(clk), .rst(rst), .start(start), .st_addr(st_addr), .burst(burst),
        .step(step), .burst_num(burst_num), .done(done),
        .din(din), .din_valid(din_valid), .din_ready(din_ready),
        .awaddr(awaddr), .awlen(awlen), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bvalid(bvalid), .bready(bready)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    int          cyc = 0;
    int          pend = 0;
    logic        b_en = 1'b1;
    logic        stall_pat = 1'b0;

    logic [31:0] aw_addr [32];
    logic [7:0]  aw_len  [32];
    int          aw_bat  [32];
    int          wl_len  [32];
    int          aw_cnt, w_cnt, wl_cnt, b_cnt, beat_in_chunk, unstable, data_bad;
    logic        aw_wait;
    logic [31:0] p_addr;
    logic [7:0]  p_len;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_logs();
        aw_cnt = 0; w_cnt = 0; wl_cnt = 0; b_cnt = 0; beat_in_chunk = 0;
        unstable = 0; data_bad = 0; pend = 0; aw_wait = 1'b0;
    endtask

    task automatic do_start(input logic [31:0] a, input logic [15:0] b,
                            input logic [31:0] s, input logic [15:0] n);
        st_addr = a; burst = b; step = s; burst_num = n;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input int max);
        int n = 0;
        while (!done && n < max) begin
            tick();
            n++;
        end
        chk("done_timeout", 64'(done), 64'(1));
    endtask

    // Slave-side drivers: bursts are acknowledged as soon as they are logged.
    always @(posedge clk) begin
        #2;
        cyc       = cyc + 1;
        bvalid    = b_en && (pend > 0);
        din_valid = stall_pat ? (cyc % 3 != 2) : 1'b1;
        wready    = stall_pat ? (cyc % 4 != 1) : 1'b1;
        awready   = stall_pat ? cyc[0] : 1'b1;
        din       = {8{cyc}};
    end

    always @(negedge clk) begin
        if (rst) begin
            if (aw_wait && awvalid && (awaddr != p_addr || awlen != p_len)) unstable++;
            aw_wait = awvalid && !awready;
            p_addr  = awaddr;
            p_len   = awlen;
            if (awvalid && awready) begin
                if (aw_cnt < 32) begin
                    aw_addr[aw_cnt] = awaddr;
                    aw_len[aw_cnt]  = awlen;
                    aw_bat[aw_cnt]  = b_cnt;
                end
                aw_cnt++;
                pend++;
            end
            if (wvalid && (din_ready != wready || !din_valid)) data_bad++;
            if (wvalid && wready) begin
                w_cnt++;
                beat_in_chunk++;
                if (wdata != din || wstrb != '1) data_bad++;
                if (wlast) begin
                    if (wl_cnt < 32) wl_len[wl_cnt] = beat_in_chunk;
                    wl_cnt++;
                    beat_in_chunk = 0;
                end
            end
            if (bvalid && bready) begin
                b_cnt++;
                if (pend > 0) pend--;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst = 1'b0; start = 1'b0; st_addr = '0; burst = '0; step = '0; burst_num = '0;
        din = '0; din_valid = 1'b0; awready = 1'b0; wready = 1'b0; bvalid = 1'b0;
        clear_logs();
        repeat (3) tick();
        rst = 1'b1;
        tick();
        chk("rst_done",      64'(done),      64'(1));
        chk("rst_awvalid",   64'(awvalid),   64'(0));
        chk("rst_wvalid",    64'(wvalid),    64'(0));
        chk("rst_din_ready", 64'(din_ready), 64'(0));
        chk("rst_wlast",     64'(wlast),     64'(0));
        chk("rst_bready",    64'(bready),    64'(1));

        // Two 16-beat rows with back-pressure everywhere; stray start mid-job.
        clear_logs(); stall_pat = 1'b1; b_en = 1'b1;
        do_start(32'h1000, 16'h200, 32'h80F, 16'd1);
        chk("s1_busy", 64'(done), 64'(0));
        repeat (3) tick();
        do_start(32'h9000, 16'h40, 32'h0, 16'd0);
        wait_done(600);
        chk("s1_b_at_done", 64'(b_cnt),      64'(2));
        chk("s1_aw_cnt",    64'(aw_cnt),     64'(2));
        chk("s1_aw0_addr",  64'(aw_addr[0]), 64'h1000);
        chk("s1_aw0_len",   64'(aw_len[0]),  64'(15));
        chk("s1_aw1_addr",  64'(aw_addr[1]), 64'h1800);
        chk("s1_aw1_len",   64'(aw_len[1]),  64'(15));
        chk("s1_w_cnt",     64'(w_cnt),      64'(32));
        chk("s1_wlast_cnt", 64'(wl_cnt),     64'(2));
        chk("s1_chunk0",    64'(wl_len[0]),  64'(16));
        chk("s1_chunk1",    64'(wl_len[1]),  64'(16));
        chk("s1_aw_stable", 64'(unstable),   64'(0));
        chk("s1_data",      64'(data_bad),   64'(0));

        // 4 KB page split; low address bits are discarded.
        clear_logs(); stall_pat = 1'b0;
        do_start(32'h0FC7, 16'h100, 32'h0, 16'd0);
        wait_done(200);
        chk("s2_aw_cnt",   64'(aw_cnt),     64'(2));
        chk("s2_aw0_addr", 64'(aw_addr[0]), 64'h0FC0);
        chk("s2_aw0_len",  64'(aw_len[0]),  64'(1));
        chk("s2_aw1_addr", 64'(aw_addr[1]), 64'h1000);
        chk("s2_aw1_len",  64'(aw_len[1]),  64'(5));
        chk("s2_w_cnt",    64'(w_cnt),      64'(8));
        chk("s2_chunk0",   64'(wl_len[0]),  64'(2));
        chk("s2_chunk1",   64'(wl_len[1]),  64'(6));

        // Outstanding limit: B withheld, ten 2-beat rows.
        clear_logs(); b_en = 1'b0;
        do_start(32'h0, 16'h40, 32'h40, 16'd9);
        repeat (60) tick();
        chk("s3_aw_stall",   64'(aw_cnt),  64'(8));
        chk("s3_w_stall",    64'(w_cnt),   64'(16));
        chk("s3_awvalid_lo", 64'(awvalid), 64'(0));
        chk("s3_busy",       64'(done),    64'(0));
        b_en = 1'b1;
        wait_done(300);
        chk("s3_aw_cnt",     64'(aw_cnt),          64'(10));
        chk("s3_aw8_addr",   64'(aw_addr[8]),      64'h200);
        chk("s3_aw9_addr",   64'(aw_addr[9]),      64'h240);
        chk("s3_b_before_9", 64'(aw_bat[8] >= 1),  64'(1));
        chk("s3_b_cnt",      64'(b_cnt),           64'(10));
        chk("s3_w_cnt",      64'(w_cnt),           64'(20));

        // Sub-beat row length: no traffic, done low for a single cycle.
        clear_logs();
        do_start(32'h100, 16'h1F, 32'h20, 16'd3);
        chk("s4_done_low",  64'(done), 64'(0));
        tick();
        chk("s4_done_back", 64'(done), 64'(1));
        repeat (5) tick();
        chk("s4_aw_cnt", 64'(aw_cnt), 64'(0));
        chk("s4_w_cnt",  64'(w_cnt),  64'(0));

        // Reset in the middle of a data phase, then a normal job.
        clear_logs();
        do_start(32'h2000, 16'h200, 32'h0, 16'd0);
        n = 0;
        @(negedge clk);
        while (!wvalid && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("s6_in_data", 64'(wvalid), 64'(1));
        #2 rst = 1'b0;
        #1;
        chk("s6_awvalid", 64'(awvalid), 64'(0));
        chk("s6_wvalid",  64'(wvalid),  64'(0));
        chk("s6_done",    64'(done),    64'(1));
        tick();
        chk("s6_hold_awvalid", 64'(awvalid), 64'(0));
        chk("s6_hold_done",    64'(done),    64'(1));
        tick();
        rst = 1'b1;
        clear_logs();
        tick();
        do_start(32'h0FC0, 16'h100, 32'h0, 16'd0);
        wait_done(200);
        chk("s6_aw_cnt",   64'(aw_cnt),     64'(2));
        chk("s6_aw0_addr", 64'(aw_addr[0]), 64'h0FC0);
        chk("s6_aw1_addr", 64'(aw_addr[1]), 64'h1000);
        chk("s6_w_cnt",    64'(w_cnt),      64'(8));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
